// File: rtl/ram_bank_pkg.sv
// ---------------------------------------------------------------------------
// ram_bank_pkg
// Shared definitions for the RAM bank sequencing controller:
//   - default address/data width constants
//   - FSM state encoding for the access sequencer
//   - chip-index width helper
// ---------------------------------------------------------------------------
package ram_bank_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_CHIP_ADDR_W = 10;
    localparam int DEF_DATA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } bank_state_e;

    // Number of request-address bits above the chip offset (the chip index).
    function automatic int chip_idx_w(input int addr_w, input int chip_addr_w);
        return addr_w - chip_addr_w;
    endfunction

endpackage

// File: rtl/ram_cs_decode.sv
// ---------------------------------------------------------------------------
// ram_cs_decode
// Combinational chip-select decoder.
//   idx       : chip index taken from the upper request address bits
//   strobe_en : 1 while the chip should be selected
//   cs_n      : one-hot active-low select (all ones when disabled/out of range)
//   in_range  : idx addresses a populated chip
// ---------------------------------------------------------------------------
module ram_cs_decode
    import ram_bank_pkg::*;
#(
    parameter int IDX_W     = 2,
    parameter int NUM_CHIPS = 4
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 strobe_en,
    output logic [NUM_CHIPS-1:0] cs_n,
    output logic                 in_range
);

    // Decode index to a single low select bit; unpopulated indices select nothing.
    always_comb begin
        in_range = (int'(idx) < NUM_CHIPS);
        cs_n     = {NUM_CHIPS{1'b1}};
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (strobe_en && (int'(idx) == i)) begin
                cs_n[i] = 1'b0;
            end else begin
                cs_n[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bank_ctrl
// Sequences single-beat read/write requests onto a bank of falling-edge
// triggered 1K x 8 RAM chips: SETUP (address stable, no select), STROBE
// (selected chip low for CS_LOW_CYCLES), RELEASE (deselect, respond).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake (ready only when idle)
//   req_we/req_addr/req_wdata  : request fields, captured on accept
//   rsp_valid/rsp_err/rsp_rdata: one-cycle response pulse, error, read data
//   ram_addr/ram_din/ram_we    : shared chip address/data/write enable
//   ram_cs_n                   : per-chip active-low select
//   ram_dout                   : concatenated chip read data
// All ram_* and rsp_* outputs come straight from flops.
// ---------------------------------------------------------------------------
module ram_bank_ctrl
    import ram_bank_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int CHIP_ADDR_W   = DEF_CHIP_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int NUM_CHIPS     = 4,
    parameter int CS_LOW_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [CHIP_ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]           ram_din,
    output logic                        ram_we,
    output logic [NUM_CHIPS-1:0]        ram_cs_n,
    input  logic [NUM_CHIPS*DATA_W-1:0] ram_dout
);

    localparam int IDX_W = chip_idx_w(ADDR_W, CHIP_ADDR_W);
    localparam int CNT_W = (CS_LOW_CYCLES > 1) ? $clog2(CS_LOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CS_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    bank_state_e          state_r;
    bank_state_e          state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 accept_s;
    logic                 last_strobe_s;
    logic                 strobe_next_s;
    logic                 in_range_s;
    logic [NUM_CHIPS-1:0] cs_n_s;
    logic [DATA_W-1:0]    rd_slice_s;

    assign accept_s = req_valid & req_ready;

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: state_s = ST_STROBE;
            ST_STROBE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_STROBE;
                end
            end
            ST_RELEASE: state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Output-side decode: selects are computed from the next state so the
    // registered cs_n changes exactly on the state transition edge.
    always_comb begin
        strobe_next_s = (state_s == ST_STROBE);
        last_strobe_s = (state_r == ST_STROBE) && (cnt_r == CNT_ZERO);
    end

    ram_cs_decode #(
        .IDX_W     (IDX_W),
        .NUM_CHIPS (NUM_CHIPS)
    ) u_cs_decode (
        .idx       (idx_r),
        .strobe_en (strobe_next_s),
        .cs_n      (cs_n_s),
        .in_range  (in_range_s)
    );

    // Read-data mux: picks the selected chip's output lane.
    always_comb begin
        rd_slice_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (int'(idx_r) == i) begin
                rd_slice_s = ram_dout[i*DATA_W +: DATA_W];
            end else begin
                rd_slice_s = rd_slice_s;
            end
        end
    end

    // State register and strobe-length down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            if (state_r == ST_SETUP) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_STROBE) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered outputs: request capture, chip selects, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            ram_cs_n  <= {NUM_CHIPS{1'b1}};
            ram_addr  <= {CHIP_ADDR_W{1'b0}};
            ram_din   <= {DATA_W{1'b0}};
            ram_we    <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            req_ready <= (state_s == ST_IDLE);
            ram_cs_n  <= cs_n_s;
            rsp_valid <= (state_s == ST_RELEASE);
            if (accept_s) begin
                ram_addr <= req_addr[CHIP_ADDR_W-1:0];
                ram_din  <= req_wdata;
                ram_we   <= req_we;
                idx_r    <= req_addr[ADDR_W-1:CHIP_ADDR_W];
            end
            // Capture read data on the edge that ends the strobe window;
            // it is held until the next response.
            if (last_strobe_s) begin
                rsp_err   <= ~in_range_s;
                rsp_rdata <= (in_range_s && !ram_we) ? rd_slice_s : {DATA_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bank_ctrl
// Two controllers share one request stream: a 4-chip bank and a 3-chip bank
// (where chip index 3 is unpopulated). Each has a behavioural chip model;
// a per-chip byte array reference predicts every response and select pattern.
// ---------------------------------------------------------------------------
module tb_ram_bank_ctrl;

    localparam int CSL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;

    logic        ready_a, rsp_valid_a, rsp_err_a, ram_we_a;
    logic [7:0]  rsp_rdata_a, ram_din_a;
    logic [9:0]  ram_addr_a;
    logic [3:0]  cs_a;
    logic [31:0] dout_a;

    logic        ready_b, rsp_valid_b, rsp_err_b, ram_we_b;
    logic [7:0]  rsp_rdata_b, ram_din_b;
    logic [9:0]  ram_addr_b;
    logic [2:0]  cs_b;
    logic [23:0] dout_b;

    logic [7:0] mem_a [0:3][0:1023];
    logic [7:0] mem_b [0:2][0:1023];
    logic [7:0] ref_a [0:3][0:1023];
    logic [7:0] ref_b [0:2][0:1023];
    logic [3:0] prev_cs_a;
    logic [2:0] prev_cs_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_bank_ctrl #(.NUM_CHIPS(4), .CS_LOW_CYCLES(CSL)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a), .rsp_rdata(rsp_rdata_a),
        .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
        .ram_cs_n(cs_a), .ram_dout(dout_a)
    );

    ram_bank_ctrl #(.NUM_CHIPS(3), .CS_LOW_CYCLES(CSL)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
        .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
        .ram_cs_n(cs_b), .ram_dout(dout_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Chip models: continuous read of the addressed byte, write on cs_n fall.
    always_comb begin
        for (int i = 0; i < 4; i++) dout_a[i*8 +: 8] = mem_a[i][ram_addr_a];
        for (int i = 0; i < 3; i++) dout_b[i*8 +: 8] = mem_b[i][ram_addr_b];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (prev_cs_a[i] === 1'b1 && cs_a[i] === 1'b0 && ram_we_a) mem_a[i][ram_addr_a] = ram_din_a;
        for (int i = 0; i < 3; i++)
            if (prev_cs_b[i] === 1'b1 && cs_b[i] === 1'b0 && ram_we_b) mem_b[i][ram_addr_b] = ram_din_b;
        prev_cs_a = cs_a;
        prev_cs_b = cs_b;
        chk_eq("cs_onehot_a", 32'($countones(~cs_a) <= 1), 32'd1);
        chk_eq("cs_onehot_b", 32'($countones(~cs_b) <= 1), 32'd1);
    end

    // One request from handshake to response; expects to start #1 after a rising edge.
    task automatic do_txn(input logic we, input logic [11:0] addr, input logic [7:0] wd);
        int n;
        int idx;
        int off;
        logic err_b;
        logic [7:0] exp_rd_a, exp_rd_b;
        logic [3:0] exp_cs_a, one_a;
        logic [2:0] exp_cs_b, one_b;
        idx   = int'(addr[11:10]);
        off   = int'(addr[9:0]);
        err_b = (idx >= 3);
        one_a = 4'b0001 << idx;
        one_b = 3'b001 << idx;
        exp_cs_a = ~one_a;
        exp_cs_b = err_b ? 3'b111 : ~one_b;
        exp_rd_a = we ? 8'h00 : ref_a[idx][off];
        exp_rd_b = (we || err_b) ? 8'h00 : ref_b[idx][off];

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!ready_a && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk_eq("ready_wait", 32'(ready_a), 32'd1);
        @(posedge clk); #1;  // accept edge T0 -> cycle 1

        for (int c = 1; c <= CSL + 3; c++) begin
            chk_eq("addr_a", 32'(ram_addr_a), 32'(off));
            chk_eq("din_a",  32'(ram_din_a),  32'(wd));
            chk_eq("we_a",   32'(ram_we_a),   32'(we));
            chk_eq("addr_b", 32'(ram_addr_b), 32'(off));
            if (c == 1) begin
                chk_eq("setup_cs_a", 32'(cs_a), 32'hF);
                chk_eq("setup_cs_b", 32'(cs_b), 32'h7);
                chk_eq("setup_ready", 32'(ready_a), 32'd0);
            end else if (c <= CSL + 1) begin
                chk_eq("strobe_cs_a", 32'(cs_a), 32'(exp_cs_a));
                chk_eq("strobe_cs_b", 32'(cs_b), 32'(exp_cs_b));
                chk_eq("strobe_rsp", 32'(rsp_valid_a), 32'd0);
                chk_eq("strobe_ready", 32'(ready_a), 32'd0);
            end else if (c == CSL + 2) begin
                chk_eq("rel_cs_a", 32'(cs_a), 32'hF);
                chk_eq("rel_cs_b", 32'(cs_b), 32'h7);
                chk_eq("rsp_valid_a", 32'(rsp_valid_a), 32'd1);
                chk_eq("rsp_valid_b", 32'(rsp_valid_b), 32'd1);
                chk_eq("rsp_err_a", 32'(rsp_err_a), 32'd0);
                chk_eq("rsp_err_b", 32'(rsp_err_b), 32'(err_b));
                chk_eq("rdata_a", 32'(rsp_rdata_a), 32'(exp_rd_a));
                chk_eq("rdata_b", 32'(rsp_rdata_b), 32'(exp_rd_b));
                chk_eq("rel_ready", 32'(ready_a), 32'd0);
            end else begin
                chk_eq("post_rsp_a", 32'(rsp_valid_a), 32'd0);
                chk_eq("post_ready_a", 32'(ready_a), 32'd1);
                chk_eq("post_ready_b", 32'(ready_b), 32'd1);
                chk_eq("hold_rdata_a", 32'(rsp_rdata_a), 32'(exp_rd_a));
            end
            if (c < CSL + 3) begin
                // Busy-time noise on the request bus must be ignored.
                req_valid = 1'b1;
                req_we    = 1'($urandom);
                req_addr  = 12'($urandom);
                req_wdata = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        if (we) begin
            ref_a[idx][off] = wd;
            if (!err_b) ref_b[idx][off] = wd;
        end
    endtask

    initial begin
        logic [11:0] a;
        logic [7:0]  d;
        int r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 1024; j++) begin
                d = 8'($urandom);
                mem_a[i][j] = d; ref_a[i][j] = d;
                if (i < 3) begin mem_b[i][j] = d; ref_b[i][j] = d; end
            end
        mem_a[3][12'h012] = 8'h3C; ref_a[3][12'h012] = 8'h3C;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 12'h000; req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_cs_a", 32'(cs_a), 32'hF);
        chk_eq("rst_cs_b", 32'(cs_b), 32'h7);
        chk_eq("rst_ready", 32'(ready_a), 32'd1);
        chk_eq("rst_rsp", 32'(rsp_valid_a), 32'd0);
        chk_eq("rst_err", 32'(rsp_err_a), 32'd0);
        chk_eq("rst_rdata", 32'(rsp_rdata_a), 32'd0);
        chk_eq("rst_addr", 32'(ram_addr_a), 32'd0);
        chk_eq("rst_din", 32'(ram_din_a), 32'd0);
        chk_eq("rst_we", 32'(ram_we_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(1'b1, 12'h005, 8'hA5);
        do_txn(1'b0, 12'hC12, 8'h00);
        do_txn(1'b1, 12'h3FF, 8'h5A);
        do_txn(1'b1, 12'h400, 8'hC3);
        do_txn(1'b0, 12'hC00, 8'h00);
        do_txn(1'b0, 12'h3FF, 8'h00);

        // Reset during the strobe of a write; data matches the reference so
        // the outcome of the interrupted write is irrelevant to later reads.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h123; req_wdata = ref_a[0][12'h123];
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk_eq("midrst_pre_cs", 32'(cs_a), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("midrst_cs_a", 32'(cs_a), 32'hF);
        chk_eq("midrst_cs_b", 32'(cs_b), 32'h7);
        chk_eq("midrst_rsp", 32'(rsp_valid_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk_eq("postrst_rsp", 32'(rsp_valid_a), 32'd0);
            chk_eq("postrst_ready", 32'(ready_a), 32'd1);
        end
        do_txn(1'b0, 12'h005, 8'h00);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: a = 12'h3FF;
                1: a = 12'h7FF;
                2: a = 12'hC00;
                3: a = {2'($urandom), 10'($urandom_range(0, 7))};
                default: a = 12'($urandom);
            endcase
            d = 8'($urandom);
            do_txn(1'($urandom), a, d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
